// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
//   Hazard/stall handshake bundle between the pipeline stages and the central
//   sequencer (pipe_ctrl).
//
//   Stage -> sequencer : stallreq_id, ex_multi_start, ex_multi_cycles,
//                        mem_req, mem_ack, except_valid, except_pc
//   Sequencer -> stage : stall[5:0] (pc/if/id/ex/mem/wb), flush, new_pc,
//                        ex_done, bus_err
//
//   modport slave  : the sequencer side (consumes requests, drives stall/flush)
//   modport master : the pipeline/testbench side
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int CNT_W = 6,
  parameter int PC_W  = 32
);
  logic             stallreq_id;
  logic             ex_multi_start;
  logic [CNT_W-1:0] ex_multi_cycles;
  logic             mem_req;
  logic             mem_ack;
  logic             except_valid;
  logic [PC_W-1:0]  except_pc;

  logic [5:0]       stall;
  logic             flush;
  logic [PC_W-1:0]  new_pc;
  logic             ex_done;
  logic             bus_err;

  modport master (
    output stallreq_id, ex_multi_start, ex_multi_cycles,
           mem_req, mem_ack, except_valid, except_pc,
    input  stall, flush, new_pc, ex_done, bus_err
  );

  modport slave (
    input  stallreq_id, ex_multi_start, ex_multi_cycles,
           mem_req, mem_ack, except_valid, except_pc,
    output stall, flush, new_pc, ex_done, bus_err
  );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Central pipeline sequencer for the 5-stage core. Merges the ID load-use,
//   EX multi-cycle and MEM bus-wait stall sources into one stall vector,
//   counts EX multi-cycle latency, times out MEM bus waits and issues a
//   single-cycle flush with redirect PC on exception.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous active-high reset
//     bus  - pipe_ctrl_if.slave: stall requests in, stall/flush/new_pc/
//            ex_done/bus_err out
//
//   Outputs are combinational from the registered state and the current
//   inputs so a hazard stalls the pipeline in the same cycle it is raised.
//   All outputs are forced to 0 while rst is high.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int CNT_W       = 6,
  parameter int MEM_TIMEOUT = 255,
  parameter int PC_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int               TMR_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // EX cycles still owed after the current one
  logic [TMR_W-1:0] tmr_q, tmr_d;   // MEM_WAIT cycles entered so far, from 1

  logic [5:0]       stall_s;
  logic             flush_s;
  logic [PC_W-1:0]  new_pc_s;
  logic             ex_done_s;
  logic             bus_err_s;

  logic             mem_wait_s;
  logic             mem_done_s;
  logic [CNT_W-1:0] n_eff_s;

  // A bus access only stalls/completes while mem_req is high; a stray ack is ignored.
  assign mem_wait_s = bus.mem_req & ~bus.mem_ack;
  assign mem_done_s = bus.mem_req &  bus.mem_ack;
  // An op length of 0 behaves like a single-cycle op.
  assign n_eff_s    = (bus.ex_multi_cycles == {CNT_W{1'b0}}) ? CNT_ONE : bus.ex_multi_cycles;

  // Next-state and same-cycle output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    stall_s   = STALL_NONE;
    flush_s   = 1'b0;
    new_pc_s  = {PC_W{1'b0}};
    ex_done_s = 1'b0;
    bus_err_s = 1'b0;

    if (rst) begin
      // Outputs stay quiet; the registers are cleared in the flop block.
      state_d = RUN;
      cnt_d   = {CNT_W{1'b0}};
      tmr_d   = {TMR_W{1'b0}};
    end else if (bus.except_valid) begin
      // Abort everything in flight, including a completing op or ack.
      flush_s  = 1'b1;
      new_pc_s = bus.except_pc;
      state_d  = RUN;
      cnt_d    = {CNT_W{1'b0}};
      tmr_d    = {TMR_W{1'b0}};
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait_s) begin
            stall_s = STALL_MEM;
            tmr_d   = TMR_ONE;
            state_d = MEM_WAIT;
          end else if (bus.ex_multi_start) begin
            stall_s = STALL_EX;
            cnt_d   = n_eff_s - CNT_ONE;
            if (n_eff_s == CNT_ONE) begin
              ex_done_s = 1'b1;
            end else begin
              state_d = EX_BUSY;
            end
          end else if (bus.stallreq_id) begin
            stall_s = STALL_ID;
          end else begin
            stall_s = STALL_NONE;
          end
        end

        EX_BUSY: begin
          if (mem_wait_s) begin
            // EX count is frozen while the bus access is outstanding.
            stall_s = STALL_MEM;
            tmr_d   = TMR_ONE;
            state_d = MEM_WAIT;
          end else begin
            stall_s = STALL_EX;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
              ex_done_s = 1'b1;
              cnt_d     = {CNT_W{1'b0}};
              state_d   = RUN;
            end else begin
              state_d = EX_BUSY;
            end
          end
        end

        MEM_WAIT: begin
          if (mem_done_s || (tmr_q == TMR_MAX)) begin
            // Ack or timeout both release the stall and resume any frozen EX op.
            bus_err_s = ~mem_done_s;
            tmr_d     = {TMR_W{1'b0}};
            state_d   = (cnt_q != {CNT_W{1'b0}}) ? EX_BUSY : RUN;
          end else begin
            stall_s = STALL_MEM;
            tmr_d   = tmr_q + TMR_ONE;
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
          tmr_d   = {TMR_W{1'b0}};
        end
      endcase
    end
  end

  // State, EX counter and MEM timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= {CNT_W{1'b0}};
      tmr_q   <= {TMR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.stall   = stall_s;
  assign bus.flush   = flush_s;
  assign bus.new_pc  = new_pc_s;
  assign bus.ex_done = ex_done_s;
  assign bus.bus_err = bus_err_s;

endmodule
